// File: rtl/pin_bus_host.sv
// Host-side bridge from a valid/ready request port to a strobe/ACK pin bus.
// Define PIN_BUS_HOST_TIMEOUT_EN to bound each ACK wait by TIMEOUT cycles.
module pin_bus_host #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] pin_ui,
    input  logic [7:0] pin_uo,
    input  logic [7:0] pin_uio_in,
    output logic [7:0] pin_uio_out,
    output logic [7:0] pin_uio_oe,
    output logic       busy
);
    // state   | meaning
    // IDLE    | ready for a request, pins released
    // SETUP   | WE/ADDR/data presented, STB low
    // STROBE  | STB high, waiting for ACK to rise
    // RELEASE | STB low, waiting for ACK to fall
    // DONE    | response valid, waiting for rsp_ready
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, DONE} state_t;

    state_t     state_q, state_n;
    logic       we_q, we_n;
    logic [5:0] addr_q, addr_n;
    logic [7:0] wdata_q, wdata_n;
    logic [7:0] ui_q, ui_n, uo_q, uo_n, oe_q, oe_n;
    logic [7:0] rdata_q, rdata_n;
    logic       ready_q, valid_q, busy_q;
    logic       ack_m, ack_s;
    logic [6:0] unused_uo;

    assign unused_uo = pin_uo[7:1];

`ifdef PIN_BUS_HOST_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_n;
    logic       err_q, err_n;
    logic       timeout_hit;

    assign timeout_hit = (cnt_q == TIMEOUT_CNT);
    assign rsp_err     = err_q;

    always_comb begin
        cnt_n = cnt_q;
        if ((state_n == STROBE && state_q != STROBE) ||
            (state_n == RELEASE && state_q != RELEASE))
            cnt_n = 8'd0;
        else if (state_q == STROBE || state_q == RELEASE)
            cnt_n = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            err_q <= err_n;
        end
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign rsp_err        = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        ui_n    = ui_q;
        uo_n    = uo_q;
        oe_n    = oe_q;
        rdata_n = rdata_q;
`ifdef PIN_BUS_HOST_TIMEOUT_EN
        err_n   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_n = SETUP;
                    we_n    = req_we;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    ui_n    = {1'b0, req_we, req_addr};
                    uo_n    = req_we ? req_wdata : 8'h00;
                    oe_n    = req_we ? 8'hFF : 8'h00;
                end
            end
            SETUP: begin
                state_n = STROBE;
                ui_n    = {1'b1, we_q, addr_q};
            end
            STROBE: begin
                if (ack_s) begin
                    state_n = RELEASE;
                    ui_n    = {1'b0, we_q, addr_q};
                    rdata_n = we_q ? 8'h00 : pin_uio_in;
                end
`ifdef PIN_BUS_HOST_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_n = DONE;
                    ui_n    = 8'h00;
                    uo_n    = 8'h00;
                    oe_n    = 8'h00;
                    rdata_n = 8'h00;
                    err_n   = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_n = DONE;
                    ui_n    = 8'h00;
                    uo_n    = 8'h00;
                    oe_n    = 8'h00;
`ifdef PIN_BUS_HOST_TIMEOUT_EN
                    err_n   = 1'b0;
`endif
                end
`ifdef PIN_BUS_HOST_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_n = DONE;
                    ui_n    = 8'h00;
                    uo_n    = 8'h00;
                    oe_n    = 8'h00;
                    rdata_n = 8'h00;
                    err_n   = 1'b1;
                end
`endif
            end
            DONE: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so req_ready stays low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= 8'h00;
            ui_q    <= 8'h00;
            uo_q    <= 8'h00;
            oe_q    <= 8'h00;
            rdata_q <= 8'h00;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_m   <= 1'b0;
            ack_s   <= 1'b0;
        end else begin
            state_q <= state_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            ui_q    <= ui_n;
            uo_q    <= uo_n;
            oe_q    <= oe_n;
            rdata_q <= rdata_n;
            ready_q <= (state_n == IDLE);
            valid_q <= (state_n == DONE);
            busy_q  <= (state_n != IDLE);
            ack_m   <= pin_uo[0];
            ack_s   <= ack_m;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = valid_q;
    assign rsp_rdata   = rdata_q;
    assign pin_ui      = ui_q;
    assign pin_uio_out = uo_q;
    assign pin_uio_oe  = oe_q;
    assign busy        = busy_q;
endmodule
